mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 16-bit-word program/data memory of the multicycle 8085 processor between two requesters: instruction fetch (IF) and data load/store (D).
- Grants one requester at a time and drives the memory port.
- Waits out the fixed memory read latency, then returns registered read data with a one-cycle valid pulse.
- Sits between the control unit/PC logic and the memory instance.

Parameters:
- AW, 8, memory word-address width.
- DW, 16, memory data width.
- MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid (legal range 1..7).
- MAX_WAIT, 3, consecutive IF arbitration losses before IF is forced to win (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- if_req  input  1  fetch request; hold with if_addr until if_gnt.
- if_addr  input  AW  fetch word address.
- if_gnt  output  1  one-cycle pulse: IF access issued.
- if_rdata  output  DW  registered fetch data.
- if_valid  output  1  one-cycle pulse: if_rdata valid.
- d_req  input  1  data request; hold with d_we/d_addr/d_wdata until d_gnt.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data word address.
- d_wdata  input  DW  write data.
- d_gnt  output  1  one-cycle pulse: D access issued.
- d_rdata  output  DW  registered load data.
- d_valid  output  1  one-cycle pulse: load data valid, or write complete.
- mem_en  output  1  memory access strobe, one cycle per access.
- mem_we  output  1  memory write enable, only when mem_en=1.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after mem_en.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0, including if_rdata/d_rdata; wait counters 0.
  - An in-flight access is abandoned: no gnt or valid is emitted for it.
  - Operation resumes on the first clock edge after reset=1.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on an edge where if_req|d_req is sampled high (cycle 0):
  - Latch the winner, address, we and wdata.
  - Go to ISSUE.
- ISSUE (cycle 1): mem_en=1; mem_we=latched we; mem_addr/mem_wdata driven; winner's gnt=1.
  - Write: next state RESP.
  - Read: next state WAIT, with the latency counter loaded to MEM_LAT-1.
- WAIT: decrement the counter. When it reaches 0 (cycle 1+MEM_LAT, mem_rdata valid), capture mem_rdata into the winner's rdata register and go to RESP.
- RESP: winner's valid=1 for exactly one cycle. Then IDLE, where new requests are sampled on the same edge.
- Timing:
  - Read: valid in cycle MEM_LAT+2 relative to request sampling; read-to-read throughput is one access per MEM_LAT+3 cycles.
  - Write: d_valid in cycle 2; memory is updated at the end of cycle 1.
- Arbitration, evaluated only in IDLE:
  - D has priority over IF.
  - if_wait (4-bit) increments each IDLE decision where if_req=1 and D wins. It clears when IF is granted or when if_req=0 in IDLE.
  - If if_wait>=MAX_WAIT and if_req=1, IF wins even if d_req=1.
- Request withdrawal: a requester may drop req before its gnt with no effect. After gnt, req is ignored until that requester's valid. A req still high in the RESP cycle is treated as a new request.
- The non-granted rdata register holds its previous value.
- mem_we, mem_addr and mem_wdata return to 0 in every cycle that mem_en=0.

Test Plan:
- Reset mid-read: issue an IF read of addr 64; pull reset=0 during WAIT. Required: all outputs 0 at once; no if_valid after release. Repeating the read then returns if_rdata=16'h0003.
- Single read latency: mem[64]=16'h0003, MEM_LAT=2, if_req/if_addr=64 sampled at cycle 0. Required: if_gnt and mem_en in cycle 1; if_valid in cycle 4 with if_rdata=16'h0003; busy high in cycles 1-4.
- Write then read: d_req, d_we=1, d_addr=65, d_wdata=16'h00A5. Required: mem_we in cycle 1, d_valid in cycle 2. A following D read of 65 returns d_rdata=16'h00A5.
- Simultaneous requests: if_req and d_req high together in IDLE (addresses 64 and 65). Required: D granted first, IF granted in the next IDLE decision; D valid precedes IF valid.
- Starvation: hold if_req=1 while d_req is re-asserted every IDLE. Required: D wins three times, the fourth grant goes to IF (MAX_WAIT=3), and if_wait then returns to 0.
- Withdrawal: assert d_req in a cycle where IF is in WAIT, then drop d_req before IDLE. Required: no d_gnt, no mem_en for D, and no d_valid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port program/data memory of the multicycle 8085 core
// between instruction fetch (IF) and data load/store (D). One access is in
// flight at a time. The access is issued for one cycle, the fixed memory read
// latency is waited out, and a one-cycle valid pulse is returned with
// registered read data.
//
// Ports
//   clk, reset       clock, asynchronous active-low reset
//   if_req/if_addr   fetch request and word address (held until if_gnt)
//   if_gnt           one-cycle pulse, fetch access issued
//   if_rdata/if_valid registered fetch data and its one-cycle valid pulse
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt            one-cycle pulse, data access issued
//   d_rdata/d_valid  registered load data; d_valid also marks write done
//   mem_en/mem_we/mem_addr/mem_wdata  memory port, all zero when idle
//   mem_rdata        memory read data, valid MEM_LAT cycles after mem_en
//   busy             high whenever an access is in progress
//
// Every output is a flop, so nothing combinational reaches the outputs.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
   localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

   state_t        state_q, state_d;
   logic          win_d_q, win_d_d;       // 1: current access belongs to D
   logic [2:0]    cnt_q, cnt_d;
   logic [3:0]    if_wait_q, if_wait_d;
   logic          if_gnt_q, if_gnt_d;
   logic          d_gnt_q, d_gnt_d;
   logic          if_valid_q, if_valid_d;
   logic          d_valid_q, d_valid_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic          busy_q, busy_d;
   logic          if_wins;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         win_d_q     <= 1'b0;
         cnt_q       <= '0;
         if_wait_q   <= '0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_d_q     <= win_d_d;
         cnt_q       <= cnt_d;
         if_wait_q   <= if_wait_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_valid_q  <= if_valid_d;
         d_valid_q   <= d_valid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   // Outputs are computed one state ahead and registered, so the value
   // produced here for state X is what appears on the pins while in X.
   always_comb begin
      state_d     = state_q;
      win_d_d     = win_d_q;
      cnt_d       = cnt_q;
      if_wait_d   = if_wait_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_valid_d  = 1'b0;
      d_valid_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if_wins     = 1'b0;

      case (state_q)
         IDLE: begin
            // D normally wins; IF wins once it has lost MAX_WAIT times in a row.
            if_wins = if_req && (!d_req || (if_wait_q >= WAIT_LIMIT));
            if (!if_req || if_wins) begin
               if_wait_d = '0;
            end else if (if_wait_q != 4'hF) begin
               if_wait_d = if_wait_q + 4'd1;
            end
            if (if_req || d_req) begin
               state_d  = ISSUE;
               win_d_d  = !if_wins;
               mem_en_d = 1'b1;
               if (if_wins) begin
                  if_gnt_d   = 1'b1;
                  mem_addr_d = if_addr;
               end else begin
                  d_gnt_d     = 1'b1;
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end
            end
         end
         ISSUE: begin
            // mem_we_q still holds the latched direction during ISSUE.
            if (mem_we_q) begin
               state_d   = RESP;
               d_valid_d = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_LOAD;
            end
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               state_d = RESP;
               if (win_d_q) begin
                  d_rdata_d = mem_rdata;
                  d_valid_d = 1'b1;
               end else begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign if_gnt    = if_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign if_valid  = if_valid_q;
   assign d_valid   = d_valid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter: a table of single transactions, hand-written
// multi-cycle sequences (async reset mid-read, simultaneous requests, IF
// starvation limit, request withdrawal) and a randomized run compared every
// cycle against a transaction-level schedule model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW       = 8;
   localparam int DW       = 16;
   localparam int MEM_LAT  = 2;
   localparam int MAX_WAIT = 3;
   localparam int RD_LAT   = MEM_LAT + 2;
   localparam int WR_LAT   = 2;
   localparam int N_RAND   = 1200;

   logic          clk;
   logic          reset;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory environment (fixed read latency) ----------------
   function automatic logic [15:0] init_val(input int a);
      if (a == 64) return 16'h0003;
      return {8'h5A, 8'(a)};
   endfunction

   logic          ram_init;
   logic [DW-1:0] ram  [0:255];
   logic [DW-1:0] pipe [0:MEM_LAT-1];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
         for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
      end else begin
         if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
         pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 16'hDEAD;
         for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign mem_rdata = pipe[MEM_LAT-1];

   logic [62:0] all_out;
   assign all_out = {if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
                     mem_en, mem_we, mem_addr, mem_wdata, busy};

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Event recorder for multi-cycle sequences (cycle numbers relative to cycle 0).
   int            rel;
   int            mem_en_n;
   int            ev_if_gnt[$], ev_d_gnt[$], ev_if_val[$], ev_d_val[$];
   logic [DW-1:0] ev_if_dat[$], ev_d_dat[$];
   bit            gnt_order[$];   // 1 = D granted, 0 = IF granted

   task automatic clear_ev();
      rel = 0;
      mem_en_n = 0;
      ev_if_gnt.delete(); ev_d_gnt.delete();
      ev_if_val.delete(); ev_d_val.delete();
      ev_if_dat.delete(); ev_d_dat.delete();
      gnt_order.delete();
   endtask

   task automatic watch(input int n, input bit drop);
      for (int i = 0; i < n; i++) begin
         tick();
         rel++;
         if (mem_en) mem_en_n++;
         if (if_gnt) begin
            ev_if_gnt.push_back(rel); gnt_order.push_back(1'b0);
            if (drop) if_req = 1'b0;
         end
         if (d_gnt) begin
            ev_d_gnt.push_back(rel); gnt_order.push_back(1'b1);
            if (drop) d_req = 1'b0;
         end
         if (if_valid) begin ev_if_val.push_back(rel); ev_if_dat.push_back(if_rdata); end
         if (d_valid)  begin ev_d_val.push_back(rel);  ev_d_dat.push_back(d_rdata);  end
      end
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
   endtask

   // ---------------- table-driven single transactions ----------------
   typedef struct {
      logic        is_d;
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;   // winner's rdata at its valid cycle
      int          exp_lat;     // valid cycle relative to request sampling
   } vec_t;

   vec_t tbl [8];

   task automatic run_entry(input vec_t e, input string nm);
      int k;
      logic v;
      logic [15:0] rd;
      if (e.is_d) begin
         d_req = 1'b1; d_we = e.we; d_addr = e.addr; d_wdata = e.wdata;
      end else begin
         if_req = 1'b1; if_addr = e.addr;
      end
      tick();   // cycle 1
      check({nm, "_issue"}, {59'd0, if_gnt, d_gnt, mem_en, mem_we, busy},
            {59'd0, !e.is_d, e.is_d, 1'b1, e.we, 1'b1});
      check({nm, "_addr"}, 64'(mem_addr), 64'(e.addr));
      if (e.we) check({nm, "_wdata"}, 64'(mem_wdata), 64'(e.wdata));
      idle_inputs();
      k = -1;
      v = 1'b0;
      for (int i = 2; i <= 20; i++) begin
         tick();
         if (i == 2) check({nm, "_port_idle"}, {31'd0, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
         v = e.is_d ? d_valid : if_valid;
         if (v) begin k = i; break; end
      end
      rd = e.is_d ? d_rdata : if_rdata;
      check({nm, "_valid_cyc"}, 64'(k), 64'(e.exp_lat));
      check({nm, "_rdata"}, 64'(rd), 64'(e.exp_rdata));
      check({nm, "_busy_resp"}, 64'(busy), 64'd1);
      tick();
      check({nm, "_back_idle"}, {61'd0, busy, if_valid, d_valid}, 64'd0);
      $display("%s: %s %s addr=%0d valid@%0d rdata=%h", nm, e.is_d ? "D" : "IF",
               e.we ? "wr" : "rd", e.addr, k, rd);
   endtask

   // ---------------- reference model state (random phase) ----------------
   logic [DW-1:0] ref_mem [0:255];
   bit            m_act, m_is_d, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_if_rd, m_d_rd;
   int            m_t0, m_done, m_wait;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit   e_iss, e_val, win_if;
      logic [7:0] ord;
      logic [6:0] e_ctrl;

      tbl[0] = '{1'b0, 1'b0, 8'd64, 16'h0000, 16'h0003, RD_LAT};
      tbl[1] = '{1'b1, 1'b1, 8'd65, 16'h00A5, 16'h0000, WR_LAT};
      tbl[2] = '{1'b1, 1'b0, 8'd65, 16'h0000, 16'h00A5, RD_LAT};
      tbl[3] = '{1'b0, 1'b0, 8'd65, 16'h0000, 16'h00A5, RD_LAT};
      tbl[4] = '{1'b1, 1'b1, 8'd10, 16'h1234, 16'h00A5, WR_LAT};
      tbl[5] = '{1'b1, 1'b0, 8'd10, 16'h0000, 16'h1234, RD_LAT};
      tbl[6] = '{1'b0, 1'b0, 8'd10, 16'h0000, 16'h1234, RD_LAT};
      tbl[7] = '{1'b1, 1'b0, 8'd64, 16'h0000, 16'h0003, RD_LAT};

      idle_inputs();
      reset = 1'b0;
      ram_init = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ram_init = 1'b0;
      check("reset_state", 64'(all_out), 64'd0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_entry(tbl[i], $sformatf("tbl%0d", i));

      // ---- async reset during WAIT of an IF read ----
      if_req = 1'b1; if_addr = 8'd64;
      tick();
      if_req = 1'b0;
      tick();
      check("rst_pre_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("rst_async_outputs", 64'(all_out), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      clear_ev();
      watch(10, 1'b1);
      check("rst_no_resp", 64'(ev_if_val.size() + ev_if_gnt.size() + mem_en_n), 64'd0);
      $display("reset mid-read: abandoned, %0d responses after release", ev_if_val.size());
      run_entry(tbl[0], "rst_repeat");

      // ---- simultaneous requests: D first, IF on next decision ----
      clear_ev();
      if_req = 1'b1; if_addr = 8'd64;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'd65;
      watch(14, 1'b1);
      check("sim_d_gnt", 64'(ev_d_gnt.size() > 0 ? ev_d_gnt[0] : -1), 64'd1);
      check("sim_d_val", 64'(ev_d_val.size() > 0 ? ev_d_val[0] : -1), 64'(RD_LAT));
      check("sim_d_dat", 64'(ev_d_dat.size() > 0 ? ev_d_dat[0] : 16'hFFFF), 64'h00A5);
      check("sim_if_gnt", 64'(ev_if_gnt.size() > 0 ? ev_if_gnt[0] : -1), 64'(RD_LAT + 2));
      check("sim_if_val", 64'(ev_if_val.size() > 0 ? ev_if_val[0] : -1), 64'(2 * RD_LAT + 1));
      check("sim_if_dat", 64'(ev_if_dat.size() > 0 ? ev_if_dat[0] : 16'hFFFF), 64'h0003);
      $display("simultaneous: d_gnt@%0d if_gnt@%0d", ev_d_gnt.size() > 0 ? ev_d_gnt[0] : -1,
               ev_if_gnt.size() > 0 ? ev_if_gnt[0] : -1);
      idle_inputs();

      // ---- starvation: both held high continuously ----
      clear_ev();
      if_req = 1'b1; if_addr = 8'd64;
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'd65;
      watch(8 * (RD_LAT + 1) - 3, 1'b0);   // covers 8 grants, period RD_LAT+1
      idle_inputs();
      ord = '0;
      for (int i = 0; i < 8 && i < gnt_order.size(); i++) ord[i] = gnt_order[i];
      check("starve_ngnt", 64'(gnt_order.size()), 64'd8);
      check("starve_order", 64'(ord), 64'h77);
      check("starve_if_gnt", 64'(ev_if_gnt.size() > 0 ? ev_if_gnt[0] : -1), 64'(3 * (RD_LAT + 1) + 1));
      $display("starvation: grant order (bit=1 D) %b", ord);
      repeat (10) tick();

      // ---- withdrawal of d_req while IF is in WAIT ----
      clear_ev();
      if_req = 1'b1; if_addr = 8'd64;
      watch(2, 1'b1);
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'd70; d_wdata = 16'hBEEF;
      watch(1, 1'b1);
      d_req = 1'b0;
      watch(7, 1'b1);
      check("wd_no_dgnt", 64'(ev_d_gnt.size() + ev_d_val.size()), 64'd0);
      check("wd_mem_en", 64'(mem_en_n), 64'd1);
      check("wd_if_val", 64'(ev_if_val.size() > 0 ? ev_if_val[0] : -1), 64'(RD_LAT));
      check("wd_ram70", 64'(ram[70]), 64'(init_val(70)));
      $display("withdrawal: d grants=%0d mem_en cycles=%0d", ev_d_gnt.size(), mem_en_n);
      idle_inputs();

      // ---- randomized run against schedule model ----
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
      m_act = 1'b0; m_wait = 0; m_if_rd = '0; m_d_rd = '0;
      m_t0 = 0; m_done = 0; m_is_d = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      for (int c = 0; c < N_RAND; c++) begin
         e_iss = m_act && (c == m_t0 + 1);
         e_val = m_act && (c == m_done);
         if (e_val && !m_we) begin
            if (m_is_d) m_d_rd = ref_mem[m_addr];
            else        m_if_rd = ref_mem[m_addr];
         end
         e_ctrl = {e_iss && !m_is_d, e_iss && m_is_d, e_val && !m_is_d, e_val && m_is_d,
                   e_iss, e_iss && m_we, m_act && (c > m_t0) && (c <= m_done)};
         check("rand_ctrl", 64'({if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_we, busy}), 64'(e_ctrl));
         check("rand_addr", 64'(mem_addr), 64'(e_iss ? m_addr : 8'd0));
         if (!(e_iss && !m_is_d))
            check("rand_wdata", 64'(mem_wdata), 64'((e_iss && m_is_d) ? m_wdata : 16'd0));
         check("rand_if_rdata", 64'(if_rdata), 64'(m_if_rd));
         check("rand_d_rdata", 64'(d_rdata), 64'(m_d_rd));
         if (e_val)
            $display("rand cyc=%0d %s %s addr=%0d data=%h", c, m_is_d ? "D" : "IF",
                     m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : (m_is_d ? m_d_rd : m_if_rd));

         // stimulus: hold until grant, occasional withdrawal, optional re-request
         if (!if_req) begin
            if ($urandom_range(0, 99) < 40) begin if_req = 1'b1; if_addr = 8'($urandom_range(0, 15)); end
         end else if (if_gnt) begin
            if ($urandom_range(0, 1) == 1) if_req = 1'b0;
         end else if ($urandom_range(0, 99) < 5) begin
            if_req = 1'b0;
         end
         if (!d_req) begin
            if ($urandom_range(0, 99) < 40) begin
               d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
               d_addr = 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
            end
         end else if (d_gnt) begin
            if ($urandom_range(0, 1) == 1) d_req = 1'b0;
         end else if ($urandom_range(0, 99) < 5) begin
            d_req = 1'b0;
         end

         // model: a decision happens in any cycle after the previous access ended
         if (!m_act || c > m_done) begin
            m_act = 1'b0;
            if (!if_req) m_wait = 0;
            if (if_req || d_req) begin
               win_if  = if_req && (!d_req || m_wait >= MAX_WAIT);
               m_act   = 1'b1;
               m_is_d  = !win_if;
               m_we    = win_if ? 1'b0 : d_we;
               m_addr  = win_if ? if_addr : d_addr;
               m_wdata = d_wdata;
               m_t0    = c;
               m_done  = c + (m_we ? WR_LAT : RD_LAT);
               if (m_we) ref_mem[m_addr] = m_wdata;
               if (win_if) m_wait = 0;
               else if (if_req) m_wait++;
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
